// File: rtl/ramp_envelope_ctrl.sv
// ============================================================================
// Module      : ramp_envelope_ctrl
// Description : Per-channel DAC ramp envelope generator. Each channel runs an
//               independent IDLE/UP/HOLD/DOWN/DONE machine that produces an
//               amplitude scale factor for the downstream DAC multiplier.
//               Optional macro RAMP_DOWN_SYNC_EN: a ramp-down request on any
//               channel in UP or HOLD ramps down every channel in UP or HOLD.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ramp_envelope_ctrl #(
  parameter int NUM_CHANNELS = 2,
  parameter int ENV_W        = 16
) (
  input  logic                          clk,
  input  logic                          aresetn,
  input  logic [NUM_CHANNELS-1:0]       start,
  input  logic [NUM_CHANNELS-1:0]       enable_ramping,
  input  logic [NUM_CHANNELS-1:0]       start_ramp_down,
  input  logic [NUM_CHANNELS*ENV_W-1:0] ramp_step,
  output logic [NUM_CHANNELS*ENV_W-1:0] envelope,
  output logic [NUM_CHANNELS-1:0]       ramp_active,
  output logic [NUM_CHANNELS-1:0]       ramp_done
);

  localparam logic [ENV_W-1:0] ENV_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_UP   = 3'd1,
    S_HOLD = 3'd2,
    S_DOWN = 3'd3,
    S_DONE = 3'd4
  } state_t;

  logic [NUM_CHANNELS-1:0] start_q;
  logic [NUM_CHANNELS-1:0] w_rise;
  logic [NUM_CHANNELS-1:0] w_rd_req;

  // Previous start level, used for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!aresetn) start_q <= '0;
    else          start_q <= start;
  end

  assign w_rise = start & ~start_q;

`ifdef RAMP_DOWN_SYNC_EN
  // Channels in UP or HOLD share one ramp-down request; the request is only
  // acted on by channels in those states, so IDLE/DONE channels are unaffected.
  logic [NUM_CHANNELS-1:0] w_up_or_hold;
  logic                    w_req_any;
  assign w_req_any = |(start_ramp_down & w_up_or_hold);
  assign w_rd_req  = {NUM_CHANNELS{w_req_any}};
`else
  assign w_rd_req = start_ramp_down;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
      state_t           state_q;
      logic [ENV_W-1:0] env_q;
      logic             active_q;
      logic             done_q;
      logic [ENV_W-1:0] w_step_raw;
      logic [ENV_W-1:0] w_step;
      logic [ENV_W:0]   w_sum;
      logic [ENV_W:0]   w_diff;

      // A zero step would stall the ramp forever, so it is promoted to 1.
      assign w_step_raw = ramp_step[gi*ENV_W +: ENV_W];
      assign w_step     = (w_step_raw == '0) ? {{(ENV_W-1){1'b0}}, 1'b1} : w_step_raw;
      // One extra bit catches overflow on the way up and borrow on the way down.
      assign w_sum      = {1'b0, env_q} + {1'b0, w_step};
      assign w_diff     = {1'b0, env_q} - {1'b0, w_step};

`ifdef RAMP_DOWN_SYNC_EN
      assign w_up_or_hold[gi] = (state_q == S_UP) || (state_q == S_HOLD);
`endif

      // Channel state machine with registered envelope and status outputs.
      always_ff @(posedge clk) begin
        if (!aresetn) begin
          state_q  <= S_IDLE;
          env_q    <= '0;
          active_q <= 1'b0;
          done_q   <= 1'b0;
        end else begin
          case (state_q)
            S_IDLE: begin
              if (w_rise[gi]) begin
                if (enable_ramping[gi]) begin
                  state_q  <= S_UP;
                  active_q <= 1'b1;
                end else begin
                  state_q <= S_HOLD;
                  env_q   <= ENV_MAX;
                end
              end
            end
            S_UP: begin
              if (!start[gi]) begin
                state_q  <= S_IDLE;
                env_q    <= '0;
                active_q <= 1'b0;
              end else if (w_rd_req[gi]) begin
                // Envelope is held on the turn-around edge.
                state_q <= S_DOWN;
              end else if (w_sum >= {1'b0, ENV_MAX}) begin
                state_q  <= S_HOLD;
                env_q    <= ENV_MAX;
                active_q <= 1'b0;
              end else begin
                env_q <= w_sum[ENV_W-1:0];
              end
            end
            S_HOLD: begin
              if (!start[gi]) begin
                state_q <= S_IDLE;
                env_q   <= '0;
              end else if (w_rd_req[gi]) begin
                if (enable_ramping[gi]) begin
                  state_q  <= S_DOWN;
                  active_q <= 1'b1;
                end else begin
                  state_q <= S_DONE;
                  env_q   <= '0;
                  done_q  <= 1'b1;
                end
              end
            end
            S_DOWN: begin
              if (!start[gi]) begin
                state_q  <= S_IDLE;
                env_q    <= '0;
                active_q <= 1'b0;
              end else if (w_diff[ENV_W] || (w_diff == '0)) begin
                state_q  <= S_DONE;
                env_q    <= '0;
                active_q <= 1'b0;
                done_q   <= 1'b1;
              end else begin
                env_q <= w_diff[ENV_W-1:0];
              end
            end
            S_DONE: begin
              if (!start[gi]) begin
                state_q <= S_IDLE;
                done_q  <= 1'b0;
              end
            end
            default: begin
              state_q  <= S_IDLE;
              env_q    <= '0;
              active_q <= 1'b0;
              done_q   <= 1'b0;
            end
          endcase
        end
      end

      assign envelope[gi*ENV_W +: ENV_W] = env_q;
      assign ramp_active[gi]             = active_q;
      assign ramp_done[gi]               = done_q;
    end
  endgenerate

endmodule

`default_nettype wire
